// File: rtl/tmr_fault_injector_if.sv
// Stream bundle between the fault injector and its neighbours.
// Upstream side:   valid_i/ready_o/data_i carry the golden operand in.
// Downstream side: valid_o/ready_i/data_o carry three replicas out, together with
//                  the expected voter verdict (exp_err_o), the flipped-bit mask
//                  (fault_mask_o) and the one-hot faulted replicas (fault_copy_o).
// Signal suffixes are from the injector's point of view.
// slave  : injector side.
// master : bench or environment side.
interface tmr_fault_injector_if #(
    parameter int unsigned WIDTH = 8
);
    logic                       valid_i;
    logic                       ready_o;
    logic [WIDTH-1:0]           data_i;
    logic                       valid_o;
    logic                       ready_i;
    logic [2:0][WIDTH-1:0]      data_o;
    logic [1:0]                 exp_err_o;
    logic [WIDTH-1:0]           fault_mask_o;
    logic [2:0]                 fault_copy_o;

    modport slave (
        input  valid_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o,
        output exp_err_o,
        output fault_mask_o,
        output fault_copy_o
    );

    modport master (
        output valid_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o,
        input  exp_err_o,
        input  fault_mask_o,
        input  fault_copy_o
    );
endinterface

// File: rtl/tmr_fault_injector.sv
// Fans a single-copy operand stream out into three replicas for a triplicated DUT and,
// on a programmable schedule, flips one LFSR-selected bit in one or two replicas.
// Every output beat carries the verdict a correct voter should produce.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   strm_io         stream bundle (slave side): operand in, replicas + verdict out
//   inject_en_i     injection enable; low forces the scheduler back to idle
//   inject_mode_i   00 none, 01 single replica, 10 two replicas same bit,
//                   11 burst of single-replica faults
//   inject_period_i inject on every Nth accepted beat (0 behaves as 1)
//   fault_cnt_o     faulted beats emitted since reset, saturating
module tmr_fault_injector #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tmr_fault_injector_if.slave   strm_io,
    input  logic                  inject_en_i,
    input  logic [1:0]            inject_mode_i,
    input  logic [7:0]            inject_period_i,
    output logic [15:0]           fault_cnt_o
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] Seed    = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam int unsigned BcntW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BcntW-1:0] BurstReload = BcntW'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StCount, StBurst} state_e;
    typedef enum logic [1:0] {KindClean, KindSingle, KindDouble} kind_e;

    state_e                state_q, state_d;
    logic [7:0]            pcnt_q, pcnt_d;
    logic [BcntW-1:0]      bcnt_q, bcnt_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  valid_q, valid_d;
    logic [2:0][WIDTH-1:0] data_q, data_d;
    logic [1:0]            err_q, err_d;
    logic [WIDTH-1:0]      mask_q, mask_d;
    logic [2:0]            copy_q, copy_d;
    logic [15:0]           fcnt_q, fcnt_d;

    logic                  stall;
    logic                  accept;
    logic                  abort;
    logic [7:0]            period_m1;
    kind_e                 kind;

    logic [31:0]           bit_sel;
    logic [WIDTH-1:0]      flip_mask;
    logic [1:0]            copy_idx;
    logic [2:0]            copy_single;
    logic [2:0]            copy_double;
    logic [2:0]            copy_sel;
    logic [WIDTH-1:0]      mask_sel;
    logic                  lfsr_fb;

    // Handshake: the single output slot is free unless it holds a beat nobody takes.
    assign stall             = valid_q && !strm_io.ready_i;
    assign strm_io.ready_o   = !stall;
    assign accept            = strm_io.valid_i && !stall;
    assign abort             = !inject_en_i || (inject_mode_i == 2'b00);
    assign period_m1         = (inject_period_i == 8'd0) ? 8'd0 : inject_period_i - 8'd1;

    // Fault position from the pre-advance LFSR value.
    assign bit_sel   = 32'(lfsr_q[7:0]) % 32'(WIDTH);
    assign flip_mask = WIDTH'(1) << bit_sel;
    assign copy_idx  = (lfsr_q[9:8] == 2'd3) ? 2'd0 : lfsr_q[9:8];

    always_comb begin
        copy_single = 3'b000;
        copy_double = 3'b000;
        unique case (copy_idx)
            2'd0: begin
                copy_single = 3'b001;
                copy_double = 3'b011;
            end
            2'd1: begin
                copy_single = 3'b010;
                copy_double = 3'b110;
            end
            2'd2: begin
                copy_single = 3'b100;
                copy_double = 3'b101;
            end
            default: begin
                copy_single = 3'b001;
                copy_double = 3'b011;
            end
        endcase
    end

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // Scheduler: decides whether the beat accepted this cycle is faulted.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        bcnt_d  = bcnt_q;
        kind    = KindClean;
        // Under backpressure nothing advances, including a pending abort.
        if (!stall) begin
            if (abort) begin
                state_d = StIdle;
                pcnt_d  = '0;
                bcnt_d  = '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_d = StCount;
                        pcnt_d  = '0;
                    end
                    StCount: begin
                        if (accept) begin
                            if (pcnt_q == period_m1) begin
                                pcnt_d = '0;
                                kind   = (inject_mode_i == 2'b10) ? KindDouble : KindSingle;
                                if (inject_mode_i == 2'b11 && BURST_LEN > 1) begin
                                    bcnt_d  = BurstReload;
                                    state_d = StBurst;
                                end
                            end else begin
                                pcnt_d = pcnt_q + 8'd1;
                            end
                        end
                    end
                    StBurst: begin
                        // Period counter stays frozen while the burst runs.
                        if (accept) begin
                            kind   = KindSingle;
                            bcnt_d = bcnt_q - BcntW'(1);
                            if (bcnt_q == BcntW'(1)) begin
                                state_d = StCount;
                            end
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        pcnt_d  = '0;
                        bcnt_d  = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        unique case (kind)
            KindSingle: copy_sel = copy_single;
            KindDouble: copy_sel = copy_double;
            default:    copy_sel = 3'b000;
        endcase
        mask_sel = (kind == KindClean) ? '0 : flip_mask;
    end

    // Output register and counters.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        mask_d  = mask_q;
        copy_d  = copy_q;
        lfsr_d  = lfsr_q;
        fcnt_d  = fcnt_q;
        if (accept) begin
            valid_d = 1'b1;
            lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
            for (int i = 0; i < 3; i++) begin
                data_d[i] = strm_io.data_i ^ (copy_sel[i] ? mask_sel : '0);
            end
            mask_d = mask_sel;
            copy_d = copy_sel;
            unique case (kind)
                KindSingle: err_d = 2'b01;
                KindDouble: err_d = 2'b10;
                default:    err_d = 2'b00;
            endcase
            if (kind != KindClean && fcnt_q != 16'hFFFF) begin
                fcnt_d = fcnt_q + 16'd1;
            end
        end else if (strm_io.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pcnt_q  <= '0;
            bcnt_q  <= '0;
            lfsr_q  <= Seed;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            copy_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            bcnt_q  <= bcnt_d;
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            copy_q  <= copy_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign strm_io.valid_o      = valid_q;
    assign strm_io.data_o       = data_q;
    assign strm_io.exp_err_o    = err_q;
    assign strm_io.fault_mask_o = mask_q;
    assign strm_io.fault_copy_o = copy_q;
    assign fault_cnt_o          = fcnt_q;

endmodule

// File: tb/tb_tmr_fault_injector.sv
// Scoreboard bench for tmr_fault_injector: the driver pushes the expected beat for every
// accepted input, the monitor compares whatever the DUT presents on its output.
module tb_tmr_fault_injector;
    localparam int unsigned W  = 8;
    localparam int unsigned BL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inject_en = 1'b0;
    logic [1:0]  inject_mode = 2'b00;
    logic [7:0]  inject_period = 8'd1;
    logic [15:0] fault_cnt;

    tmr_fault_injector_if #(.WIDTH(W)) strm ();

    tmr_fault_injector #(
        .WIDTH     (W),
        .BURST_LEN (BL),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .strm_io         (strm),
        .inject_en_i     (inject_en),
        .inject_mode_i   (inject_mode),
        .inject_period_i (inject_period),
        .fault_cnt_o     (fault_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][W-1:0] data;
        logic [1:0]        err;
        logic [W-1:0]      mask;
        logic [2:0]        copy;
        logic [15:0]       cnt;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    // Reference state
    logic        m_valid;
    logic [15:0] m_lfsr;
    int          m_st;      // 0 idle, 1 count, 2 burst
    int          m_pcnt;
    int          m_bcnt;
    int          m_fcnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    // kind: 0 clean, 1 single replica, 2 two replicas
    function automatic beat_t make_beat(input logic [15:0] l, input logic [W-1:0] d,
                                        input int kind, input int cnt);
        beat_t        b;
        int           bi;
        int           c;
        logic [W-1:0] m;
        bi = int'(l[7:0]) % int'(W);
        m = '0;
        m[bi] = 1'b1;
        c = int'(l[9:8]);
        if (c == 3) c = 0;
        b.copy = 3'b000;
        if (kind >= 1) b.copy[c] = 1'b1;
        if (kind == 2) b.copy[(c + 1) % 3] = 1'b1;
        b.mask = (kind == 0) ? '0 : m;
        b.err  = (kind == 0) ? 2'b00 : ((kind == 1) ? 2'b01 : 2'b10);
        for (int i = 0; i < 3; i++) b.data[i] = d ^ (b.copy[i] ? b.mask : '0);
        b.cnt = 16'(cnt);
        return b;
    endfunction

    function automatic beat_t mk(input logic [W-1:0] r2, input logic [W-1:0] r1,
                                 input logic [W-1:0] r0, input logic [1:0] err,
                                 input logic [W-1:0] mask, input logic [2:0] copy,
                                 input logic [15:0] cnt);
        beat_t b;
        b.data = {r2, r1, r0};
        b.err  = err;
        b.mask = mask;
        b.copy = copy;
        b.cnt  = cnt;
        return b;
    endfunction

    // One clock cycle of stimulus; starts and ends 1 time unit after a rising edge.
    task automatic step_x(input logic v, input logic [W-1:0] d, input logic rdy,
                          input logic has_hand, input beat_t hand);
        logic  m_ready;
        logic  stall;
        logic  acc;
        int    kind;
        int    p;
        beat_t b;
        strm.valid_i = v;
        strm.data_i  = d;
        strm.ready_i = rdy;
        #1;
        m_ready = !m_valid || rdy;
        check("ready_o", 64'(strm.ready_o), 64'(m_ready));
        stall = m_valid && !rdy;
        acc   = v && m_ready;
        if (!stall) begin
            kind = 0;
            if (!inject_en || inject_mode == 2'b00) begin
                m_st = 0;
                m_pcnt = 0;
                m_bcnt = 0;
            end else begin
                case (m_st)
                    0: begin
                        m_st = 1;
                        m_pcnt = 0;
                    end
                    1: if (acc) begin
                        p = (inject_period == 8'd0) ? 1 : int'(inject_period);
                        if (m_pcnt == p - 1) begin
                            m_pcnt = 0;
                            kind = (inject_mode == 2'b10) ? 2 : 1;
                            if (inject_mode == 2'b11 && BL > 1) begin
                                m_bcnt = BL - 1;
                                m_st = 2;
                            end
                        end else begin
                            m_pcnt++;
                        end
                    end
                    default: if (acc) begin
                        kind = 1;
                        m_bcnt--;
                        if (m_bcnt == 0) m_st = 1;
                    end
                endcase
            end
            if (acc) begin
                if (kind != 0 && m_fcnt < 65535) m_fcnt++;
                b = has_hand ? hand : make_beat(m_lfsr, d, kind, m_fcnt);
                exp_q.push_back(b);
                m_lfsr = lfsr_next(m_lfsr);
                m_valid = 1'b1;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic rdy);
        step_x(v, d, rdy, 1'b0, '0);
    endtask

    task automatic step_hand(input logic [W-1:0] d, input beat_t hand);
        step_x(1'b1, d, 1'b1, 1'b1, hand);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        strm.valid_i = 1'b0;
        strm.ready_i = 1'b1;
        exp_q.delete();
        m_valid = 1'b0;
        m_lfsr  = 16'hACE1;
        m_st    = 0;
        m_pcnt  = 0;
        m_bcnt  = 0;
        m_fcnt  = 0;
        @(posedge clk);
        #1;
        check("rst_valid_o", 64'(strm.valid_o), 64'(0));
        check("rst_data_o", 64'(strm.data_o), 64'(0));
        check("rst_exp_err_o", 64'(strm.exp_err_o), 64'(0));
        check("rst_fault_mask_o", 64'(strm.fault_mask_o), 64'(0));
        check("rst_fault_copy_o", 64'(strm.fault_copy_o), 64'(0));
        check("rst_fault_cnt_o", 64'(fault_cnt), 64'(0));
        check("rst_ready_o", 64'(strm.ready_o), 64'(1));
        rst_n = 1'b1;
    endtask

    // Monitor: compares the presented beat every cycle it is valid, pops on handshake.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && strm.valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(1), 64'(0));
            end else begin
                e = exp_q[0];
                check("data_o", 64'(strm.data_o), 64'(e.data));
                check("exp_err_o", 64'(strm.exp_err_o), 64'(e.err));
                check("fault_mask_o", 64'(strm.fault_mask_o), 64'(e.mask));
                check("fault_copy_o", 64'(strm.fault_copy_o), 64'(e.copy));
                check("fault_cnt_o", 64'(fault_cnt), 64'(e.cnt));
                if (strm.ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        strm.valid_i = 1'b0;
        strm.data_i  = '0;
        strm.ready_i = 1'b1;
        @(posedge clk);
        #1;

        // Clean path with injection disabled; one-cycle latency.
        do_reset();
        inject_en = 1'b0; inject_mode = 2'b00; inject_period = 8'd1;
        step_hand(8'h25, mk(8'h25, 8'h25, 8'h25, 2'b00, 8'h00, 3'b000, 16'd0));
        check("latency_valid_o", 64'(strm.valid_o), 64'(1));
        drain();
        check("clean_fault_cnt", 64'(fault_cnt), 64'(0));

        // Single fault on the first beat after reset (LFSR = ACE1: bit 1, copy 0).
        do_reset();
        inject_en = 1'b1; inject_mode = 2'b01; inject_period = 8'd1;
        step(1'b0, '0, 1'b1);
        step_hand(8'h25, mk(8'h25, 8'h25, 8'h27, 2'b01, 8'h02, 3'b001, 16'd1));
        drain();
        check("single_fault_cnt", 64'(fault_cnt), 64'(1));

        // Double fault, same seed: copies 0 and 1.
        do_reset();
        inject_en = 1'b1; inject_mode = 2'b10; inject_period = 8'd1;
        step(1'b0, '0, 1'b1);
        step_hand(8'h25, mk(8'h25, 8'h27, 8'h27, 2'b10, 8'h02, 3'b011, 16'd1));
        drain();

        // Period 3 over 9 beats, then period 0 faults every beat.
        do_reset();
        inject_en = 1'b1; inject_mode = 2'b01; inject_period = 8'd3;
        step(1'b0, '0, 1'b1);
        for (int i = 1; i <= 9; i++) step(1'b1, W'(i * 17), 1'b1);
        drain();
        check("period3_fault_cnt", 64'(fault_cnt), 64'(3));
        inject_period = 8'd0;
        for (int i = 0; i < 4; i++) step(1'b1, W'(8'hC3 + i), 1'b1);
        drain();
        check("period0_fault_cnt", 64'(fault_cnt), 64'(7));

        // Burst mode, period 2, 10 beats: beats 2-5 and 7-10 faulted.
        do_reset();
        inject_en = 1'b1; inject_mode = 2'b11; inject_period = 8'd2;
        step(1'b0, '0, 1'b1);
        for (int i = 1; i <= 10; i++) step(1'b1, W'(8'hA0 + i), 1'b1);
        drain();
        check("burst_fault_cnt", 64'(fault_cnt), 64'(8));

        // Burst aborted after its third faulted beat.
        do_reset();
        inject_en = 1'b1; inject_mode = 2'b11; inject_period = 8'd2;
        step(1'b0, '0, 1'b1);
        for (int i = 1; i <= 4; i++) step(1'b1, W'(8'h10 + i), 1'b1);
        inject_en = 1'b0;
        for (int i = 5; i <= 6; i++) step(1'b1, W'(8'h10 + i), 1'b1);
        drain();
        check("abort_fault_cnt", 64'(fault_cnt), 64'(3));

        // Backpressure for 5 cycles; the LFSR must not advance meanwhile.
        do_reset();
        inject_en = 1'b1; inject_mode = 2'b01; inject_period = 8'd1;
        step(1'b0, '0, 1'b1);
        step_hand(8'h5A, mk(8'h5A, 8'h5A, 8'h58, 2'b01, 8'h02, 3'b001, 16'd1));
        for (int i = 0; i < 5; i++) step(1'b1, 8'h3C, 1'b0);
        // LFSR = 5670: bit 0, copy 2
        step_hand(8'h3C, mk(8'h3D, 8'h3C, 8'h3C, 2'b01, 8'h01, 3'b100, 16'd2));
        drain();

        // Reset in the middle of a burst, then replay from the seed.
        do_reset();
        inject_en = 1'b1; inject_mode = 2'b11; inject_period = 8'd2;
        step(1'b0, '0, 1'b1);
        for (int i = 1; i <= 3; i++) step(1'b1, W'(8'h40 + i), 1'b1);
        do_reset();
        step(1'b0, '0, 1'b1);
        step(1'b1, 8'h41, 1'b1);
        step_hand(8'h3C, mk(8'h3D, 8'h3C, 8'h3C, 2'b01, 8'h01, 3'b100, 16'd1));
        for (int i = 3; i <= 10; i++) step(1'b1, W'(8'h40 + i), 1'b1);
        drain();
        check("replay_fault_cnt", 64'(fault_cnt), 64'(8));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/tmr_fault_injector.md
# tmr_fault_injector

Stimulus-side companion to the TMR voted datapaths in the fault-tolerance test environment. Takes a single-copy operand stream and fans it out into three replicas for a triplicated DUT input. On a programmable schedule it flips LFSR-selected bits in one or two replicas. Each output beat carries the expected voter verdict, so a checker can compare it against the DUT's voted result and error outputs.

## Interface
Parameters:
- WIDTH, 8, bits per replica (1..256)
- BURST_LEN, 4, faulted beats per burst in mode 11 (>=1)
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1

Ports:
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- data_i  in  WIDTH  golden operand
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts output beat
- data_o  out  [2:0][WIDTH]  replicas 0..2
- exp_err_o  out  2  verdict for current data_o: 00 clean, 01 correctable, 10 uncorrectable
- fault_mask_o  out  WIDTH  flipped-bit mask of current beat (0 if clean)
- fault_copy_o  out  3  one-hot faulted replicas of current beat
- inject_en_i  in  1  injection enable
- inject_mode_i  in  2  00 none, 01 single replica, 10 two replicas same bit, 11 burst of single-replica faults
- inject_period_i  in  8  inject on every Nth accepted beat; 0 treated as 1
- fault_cnt_o  out  16  faulted beats emitted since reset, saturating at 16'hFFFF

## Operation
- Single output register stage. ready_o = !valid_o || ready_i (combinational).
- Accept = valid_i && ready_o. On accept, the register loads all three replicas from data_i, applying the fault decision below.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances exactly once per accept and uses its pre-advance value for the decision.
- Fault position:
  - bit = lfsr[7:0] mod WIDTH; mask = 1<<bit.
  - copy c = lfsr[9:8], with the value 3 mapped to 0.
  - Second copy in mode 10 = (c+1) mod 3.
- FSM states IDLE, COUNT, BURST:
  - IDLE: entered at reset or whenever inject_en_i=0; period counter held at 0. Goes to COUNT when inject_en_i=1 and inject_mode_i!=00.
  - COUNT: each accept increments the period counter. The accept at counter == max(period,1)-1 is a trigger beat, and the counter clears to 0.
    - Trigger in mode 01: flip mask in copy c; exp_err 01.
    - Trigger in mode 10: flip in c and c+1; exp_err 10.
    - Trigger in mode 11: flip as in mode 01, load burst counter with BURST_LEN-1, and go to BURST (stay in COUNT if BURST_LEN=1).
  - BURST: every accept is single-replica faulted with a fresh LFSR decision and decrements the burst counter. At 0 the FSM returns to COUNT. The period counter is frozen during BURST.
- Non-trigger beats are clean: exp_err 00, mask 0, copy 000.
- Mode and period are sampled at accept. Changing the mode mid-COUNT does not clear the counter.
- inject_en_i=0 or mode 00 in any state: the next state is IDLE and any burst is aborted. The beat accepted in that same cycle is clean.
- fault_cnt_o increments by 1 on every accept whose beat is faulted.

## Timing
- Latency: accept at edge N makes data_o, valid_o, exp_err_o, fault_mask_o and fault_copy_o valid after edge N. These signals are stable while valid_o && !ready_i.
- Throughput is one beat per cycle when ready_i=1. Simultaneous drain and load is allowed.
- Backpressure: while valid_o && !ready_i, ready_o=0; the LFSR, FSM and counters hold.
- Reset (rst_n=0 at an edge), including in the middle of a beat or burst:
  - valid_o=0, data_o=0, exp_err_o=00, fault_mask_o=0, fault_copy_o=000.
  - fault_cnt_o=0, lfsr=seed, FSM IDLE, period and burst counters 0.
  - ready_o=1 in the cycle after reset.
- fault_cnt_o updates on the same edge as the faulted beat's load.

## Test plan
- Reset/clean path: seed ACE1, WIDTH=8, inject_en=0, data_i=0x25 -> data_o={0x25,0x25,0x25}, exp_err 00, fault_cnt 0, 1-cycle latency.
- Single fault: en=1, mode 01, period 1, data 0x25 -> first beat has replica0=0x27, replicas 1 and 2 =0x25, mask 0x02, copy 001, exp_err 01, fault_cnt 1.
- Double fault: same seed, mode 10, data 0x25 -> replicas {0x27,0x27,0x25}, copy 011, exp_err 10.
- Period 3, mode 01, 9 back-to-back beats -> beats 3, 6 and 9 faulted, fault_cnt 3; period 0 -> every beat faulted.
- Burst: mode 11, BURST_LEN 4, period 2, 10 beats -> beats 2-5 faulted and beats 7-10 faulted (counter frozen during burst, restarts after); deassert en after beat 3 of a burst -> remaining beats clean.
- Backpressure and reset: hold ready_i=0 for 5 cycles -> ready_o=0, outputs stable, LFSR unchanged; rst_n=0 mid-burst -> all outputs at reset values, replaying the stimulus reproduces identical masks.
